// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State codes are plain constants so older tools that expect fixed encodings keep working.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef logic [1:0] state_t;
    localparam state_t ST_BOOT  = 2'd0;
    localparam state_t ST_IDLE  = 2'd1;
    localparam state_t ST_FETCH = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-slot fetch FIFO built as a shift pair: slot 0 is always the head, so the
// head outputs come straight from registers. A flush wins over a same-cycle push.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] push_instr,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    input  logic            flush,
    output logic [1:0]      count,
    output logic            valid,
    output logic [XLEN-1:0] head_instr,
    output logic [XLEN-1:0] head_pc
);

    fetch_entry_t head_r;
    fetch_entry_t tail_r;
    logic [1:0]   count_r;
    logic         valid_r;

    fetch_entry_t in_s;
    fetch_entry_t head_nxt_s;
    fetch_entry_t tail_nxt_s;
    logic [1:0]   count_nxt_s;
    logic         pop_ok_s;
    logic         push_ok_s;

    assign in_s      = {push_instr, push_pc};
    assign pop_ok_s  = pop && (count_r != 2'd0);
    assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);

    // Next contents of the two slots and the occupancy count.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_nxt_s = in_s;
                    end else begin
                        tail_nxt_s = in_s;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_nxt_s = tail_r;
                    end else begin
                        head_nxt_s = head_r;
                    end
                    count_nxt_s = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = in_s;
                    end else begin
                        head_nxt_s = in_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Slot, count and head-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {(2*XLEN){1'b0}};
            tail_r  <= {(2*XLEN){1'b0}};
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

    assign count      = count_r;
    assign valid      = valid_r;
    assign head_instr = head_r.instr;
    assign head_pc    = head_r.pc;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the PC, issues one instruction-memory request at a time,
// buffers returns for ID and squashes wrong-path fetches on redirect or exception.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int unsigned MAX_WAIT   = 15
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exception,
    output logic        busy_timeout
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] addr_r;
    logic        req_r;
    logic [7:0]  wait_cnt_r;
    logic        timeout_r;

    state_t      state_nxt_s;
    logic [31:0] pc_nxt_s;
    logic [31:0] addr_nxt_s;
    logic [7:0]  wait_cnt_nxt_s;
    logic        push_s;
    logic        pop_s;
    logic        flush_s;
    logic [31:0] flush_pc_s;
    logic [31:0] pc_inc_s;
    logic [1:0]  count_s;
    logic        buf_valid_s;
    logic        start_idle_s;
    logic        start_post_s;

    assign pop_s      = buf_valid_s && !id_stall;
    assign flush_s    = exception || redirect;
    assign flush_pc_s = exception ? EXC_VECTOR : word_align(redirect_pc);
    assign pc_inc_s   = pc_r + PC_STEP;

    // A new request may only issue if its return is guaranteed a free slot.
    assign start_idle_s = (({1'b0, count_s}) - {2'b00, pop_s}) <= 3'd1;
    assign start_post_s = (({1'b0, count_s}) + 3'd1 - {2'b00, pop_s}) <= 3'd1;

    // Sequencer next-state, PC and request-address selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        addr_nxt_s  = addr_r;
        push_s      = 1'b0;
        case (state_r)
            ST_BOOT, ST_IDLE: begin
                if (flush_s) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = flush_pc_s;
                    addr_nxt_s  = flush_pc_s;
                end else if ((state_r == ST_BOOT) || start_idle_s) begin
                    state_nxt_s = ST_FETCH;
                    addr_nxt_s  = pc_r;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FETCH: begin
                if (flush_s) begin
                    pc_nxt_s = flush_pc_s;
                    if (imem_ready) begin
                        state_nxt_s = ST_FETCH;
                        addr_nxt_s  = flush_pc_s;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    push_s   = 1'b1;
                    pc_nxt_s = pc_inc_s;
                    if (start_post_s) begin
                        state_nxt_s = ST_FETCH;
                        addr_nxt_s  = pc_inc_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (flush_s) begin
                    pc_nxt_s = flush_pc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                // The wrong-path return is dropped; restart at the latest target.
                if (imem_ready) begin
                    state_nxt_s = ST_FETCH;
                    addr_nxt_s  = pc_nxt_s;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Per-request wait counter, saturating so a hung memory cannot wrap it.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (req_r && !imem_ready) begin
            if (wait_cnt_r != 8'hFF) begin
                wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r;
            end
        end else begin
            wait_cnt_nxt_s = 8'd0;
        end
    end

    // Sequencer state, PC, request outputs and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            wait_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            addr_r     <= addr_nxt_s;
            req_r      <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DRAIN);
            wait_cnt_r <= wait_cnt_nxt_s;
            timeout_r  <= timeout_r || (wait_cnt_nxt_s == MAX_WAIT_C);
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_instr (imem_rdata),
        .push_pc    (addr_r),
        .pop        (pop_s),
        .flush      (flush_s),
        .count      (count_s),
        .valid      (buf_valid_s),
        .head_instr (if_instr),
        .head_pc    (if_pc)
    );

    assign imem_req     = req_r;
    assign imem_addr    = addr_r;
    assign if_valid     = buf_valid_s;
    assign busy_timeout = timeout_r;

endmodule
